// File: rtl/seq_divider_32_pkg.sv
// Shared constants and small arithmetic helpers for the sequential MIPS DIV/DIVU unit.
package seq_divider_32_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  localparam int DIV_LATENCY = 33;

  localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a two's-complement value, only when the signed view applies.
  function automatic logic [DIV_W-1:0] abs_w(input logic [DIV_W-1:0] x, input logic en);
    return (en && x[DIV_W-1]) ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle between the pipeline (master) and the divider (slave).
interface seq_divider_32_if
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_W
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_32_sub.sv
// Existing 32-bit subtractor: diff = a + ~b + cin; cout=1 means no borrow.
module _32bit_sub (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] diff_o,
  output logic        cout_o
);

  assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {32'd0, cin_i};

endmodule

// File: rtl/seq_divider_32.sv
// Restoring shift/subtract divider: one trial subtraction per clock, 33 clocks accept-to-done.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  seq_divider_32_if.slave div_if
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             msb_out;
  logic             no_borrow;
  logic             take;

  assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign msb_out = rem_q[WIDTH-1];

  _32bit_sub u_sub (
    .a_i    (shifted),
    .b_i    (dvs_q),
    .cin_i  (1'b1),
    .diff_o (diff),
    .cout_o (no_borrow)
  );

  // The bit shifted out of rem is an implicit 33rd bit: if set, the subtraction always fits.
  assign take = msb_out | no_borrow;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sgn_quo_d   = sgn_quo_q;
    sgn_rem_d   = sgn_rem_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (div_if.start) begin
          sgn_quo_d = div_if.is_signed & (div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1]);
          sgn_rem_d = div_if.is_signed & div_if.dividend[WIDTH-1];
          dvs_d     = abs_w(div_if.divisor, div_if.is_signed);
          quo_d     = abs_w(div_if.dividend, div_if.is_signed);
          rem_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = take ? diff : shifted;
        quo_d = {quo_q[WIDTH-2:0], take};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        // With a zero divisor rem ends as |dividend|, so the sign fixup restores the raw dividend.
        if (dvs_q == '0) begin
          quotient_d = DIV_BY_ZERO_Q;
        end else begin
          quotient_d = sgn_quo_q ? neg_w(quo_q) : quo_q;
        end
        remainder_d = sgn_rem_q ? neg_w(rem_q) : rem_q;
        dbz_d       = (dvs_q == '0);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      sgn_quo_q   <= 1'b0;
      sgn_rem_q   <= 1'b0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sgn_quo_q   <= sgn_quo_d;
      sgn_rem_q   <= sgn_rem_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quotient_q;
  assign div_if.remainder   = remainder_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: hand-computed DIV/DIVU results, latency and handshake corners.
module tb_seq_divider_32;
  import seq_divider_32_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_divider_32_if #(.WIDTH(32)) dif ();

  seq_divider_32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start pulse, then scramble the operands after the accept edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1;
    dif.start     = 1'b0;
    dif.is_signed = ~s;
    dif.dividend  = 32'hDEAD_BEEF;
    dif.divisor   = 32'h0000_0003;
  endtask

  // Count edges until done; 41 means timeout. busy_drop flags busy falling early.
  task automatic wait_done(output int lat, output logic busy_drop);
    lat = 41;
    busy_drop = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1) begin
        lat = n;
        break;
      end
      if (dif.busy !== 1'b1) busy_drop = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int   lat;
    logic bd;
    issue(s, a, b);
    chk({tag, "_busy_at_accept"}, 32'(dif.busy), 32'd1);
    wait_done(lat, bd);
    chk({tag, "_latency"}, 32'(lat), 32'(DIV_LATENCY));
    chk({tag, "_busy_held"}, 32'(bd), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(dif.busy), 32'd0);
    chk({tag, "_quotient"}, dif.quotient, eq);
    chk({tag, "_remainder"}, dif.remainder, er);
    chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(edz));
  endtask

  initial begin
    int   lat;
    logic bd;
    int   seen;
    checks    = 0;
    failures  = 0;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_quotient", dif.quotient, 32'd0);
    chk("rst_remainder", dif.remainder, 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    chk("done_falls", 32'(dif.done), 32'd0);
    chk("quotient_holds", dif.quotient, 32'd14);

    run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("divu_1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Second start while busy must be dropped.
    issue(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd2);
    wait_done(lat, bd);
    chk("ignore_latency", 32'(lat + 10), 32'(DIV_LATENCY));
    chk("ignore_quotient", dif.quotient, 32'd10);
    chk("ignore_remainder", dif.remainder, 32'd0);

    // Start presented in the done cycle is accepted.
    run_op("b2b_9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0);

    // Reset mid-operation: asynchronous clear, no done pulse afterwards.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_quotient", dif.quotient, 32'd0);
    chk("abort_remainder", dif.remainder, 32'd0);
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
